branch_target_predictor: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage pipeline. It combines a direct-mapped branch target buffer with per-entry saturating direction counters. The IF stage queries it combinationally with the fetch PC to get a predicted next PC. The EX stage reports each resolved branch or jump back to it, and it returns a mispredict flag plus the corrected redirect PC. It replaces the EX-resolved, always-not-taken policy with trained prediction and adds saturating performance counters.

---
 rtl/branch_target_predictor.sv | 131 +++++++++++++
 tb/tb_branch_target_predictor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters: combinational
// fetch-time prediction, EX-time mispredict detection, training and perf counters.
module branch_target_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_hit,
    output logic              if_pred_taken,
    output logic [XLEN-1:0]   if_pred_npc,
    input  logic              ex_valid,
    input  logic              ex_is_jump,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_npc,
    output logic              ex_mispredict,
    output logic [XLEN-1:0]   ex_redirect_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_WT - CTR_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [XLEN-1:0]   target_q [ENTRIES];
    logic [XLEN-1:0]   target_d [ENTRIES];
    logic              jump_q   [ENTRIES];
    logic              jump_d   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];
    logic [CTR_W-1:0]  ctr_d    [ENTRIES];
    logic [PERF_W-1:0] perf_branches_q, perf_branches_d;
    logic [PERF_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             ex_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        if_pred_taken = if_hit && (jump_q[if_idx] || ctr_q[if_idx][CTR_W-1]);
        if_pred_npc   = if_pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);
    end

    // ex_valid qualifies every ex_* input for exactly one cycle; there is no
    // back-pressure, the predictor always accepts the resolved branch.
    assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_mispredict  = ex_valid && ((ex_pred_taken != ex_taken) ||
                                         (ex_taken && (ex_pred_npc != ex_target)));
    assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        jump_d   = jump_q;
        ctr_d    = ctr_q;
        if (ex_valid) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    target_d[ex_idx] = ex_target;
                    if (ctr_q[ex_idx] != CTR_MAX) ctr_d[ex_idx] = ctr_q[ex_idx] + CTR_W'(1);
                end else if (ctr_q[ex_idx] != '0) begin
                    ctr_d[ex_idx] = ctr_q[ex_idx] - CTR_W'(1);
                end
                jump_d[ex_idx] = ex_is_jump;
                if (ex_is_jump) ctr_d[ex_idx] = CTR_MAX;
            end else if (ex_taken) begin
                // Allocate on taken; whatever lived in this slot is simply replaced.
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_target;
                jump_d[ex_idx]   = ex_is_jump;
                ctr_d[ex_idx]    = ex_is_jump ? CTR_MAX : CTR_WT;
            end
        end
    end

    always_comb begin
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (ex_valid && (perf_branches_q != PERF_MAX))
            perf_branches_d = perf_branches_q + PERF_W'(1);
        if (ex_mispredict && (perf_mispredicts_q != PERF_MAX))
            perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                jump_q[i]   <= 1'b0;
                ctr_q[i]    <= CTR_WNT;
            end
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            jump_q             <= jump_d;
            ctr_q              <= ctr_d;
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: a driver pushes expected outputs
// from an array-based reference model; a negedge monitor pops and compares.
module tb_branch_target_predictor;
  localparam int XLEN     = 32;
  localparam int ENTRIES  = 16;
  localparam int CTR_W    = 2;
  localparam int PERF_W   = 6;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int CTR_WT   = 1 << (CTR_W - 1);
  localparam int PERF_MAX = (1 << PERF_W) - 1;
  localparam int EXP_W    = 3 + 2 * XLEN + 2 * PERF_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   if_pc;
  logic              if_hit, if_pred_taken;
  logic [XLEN-1:0]   if_pred_npc;
  logic              ex_valid, ex_is_jump, ex_taken, ex_pred_taken;
  logic [XLEN-1:0]   ex_pc, ex_target, ex_pred_npc;
  logic              ex_mispredict;
  logic [XLEN-1:0]   ex_redirect_pc;
  logic [PERF_W-1:0] perf_branches, perf_mispredicts;

  always #5 clk = ~clk;

  branch_target_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_hit(if_hit),
    .if_pred_taken(if_pred_taken), .if_pred_npc(if_pred_npc),
    .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_npc(ex_pred_npc), .ex_mispredict(ex_mispredict),
    .ex_redirect_pc(ex_redirect_pc), .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  // reference model: one slot per index, plain integers for counters
  bit              m_valid  [ENTRIES];
  logic [XLEN-1:0] m_tag    [ENTRIES];
  logic [XLEN-1:0] m_target [ENTRIES];
  bit              m_jump   [ENTRIES];
  int              m_ctr    [ENTRIES];
  int              m_pb, m_pm;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_jump[i]   = 0;
      m_ctr[i]    = CTR_WT - 1;
    end
    m_pb = 0;
    m_pm = 0;
  endfunction

  function automatic int slot_of(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_lookup(input logic [XLEN-1:0] pc, output bit hit,
                                       output bit taken, output logic [XLEN-1:0] npc);
    int s;
    s     = slot_of(pc);
    hit   = m_valid[s] && (m_tag[s] == tag_of(pc));
    taken = hit && (m_jump[s] || m_ctr[s] >= CTR_WT);
    npc   = taken ? m_target[s] : pc + 4;
  endfunction

  function automatic void model_train(input logic [XLEN-1:0] pc, input bit is_jump,
                                      input bit taken, input logic [XLEN-1:0] tgt);
    int s;
    s = slot_of(pc);
    if (m_valid[s] && m_tag[s] == tag_of(pc)) begin
      if (taken) begin
        m_ctr[s]    = (m_ctr[s] < CTR_MAX) ? m_ctr[s] + 1 : CTR_MAX;
        m_target[s] = tgt;
      end else begin
        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
      end
      m_jump[s] = is_jump;
      if (is_jump) m_ctr[s] = CTR_MAX;
    end else if (taken) begin
      m_valid[s]  = 1;
      m_tag[s]    = tag_of(pc);
      m_target[s] = tgt;
      m_jump[s]   = is_jump;
      m_ctr[s]    = is_jump ? CTR_MAX : CTR_WT;
    end
  endfunction

  function automatic void check(input string name, input logic [XLEN-1:0] act,
                                input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // driver: apply one cycle of inputs, push expectation, then advance the model
  task automatic do_cycle(input bit r, input logic [XLEN-1:0] ipc, input bit ev,
                          input bit isj, input logic [XLEN-1:0] epc, input bit tk,
                          input logic [XLEN-1:0] tgt, input bit ptk,
                          input logic [XLEN-1:0] pnpc);
    bit h, t, mp;
    logic [XLEN-1:0] n, redir;
    @(posedge clk);
    #1;
    rst = r; if_pc = ipc; ex_valid = ev; ex_is_jump = isj; ex_pc = epc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_npc = pnpc;
    model_lookup(ipc, h, t, n);
    mp    = ev && ((ptk != tk) || (tk && pnpc != tgt));
    redir = tk ? tgt : epc + 4;
    exp_q.push_back({h, t, n, mp, redir, PERF_W'(m_pb), PERF_W'(m_pm)});
    if (r) begin
      model_reset();
    end else if (ev) begin
      model_train(epc, isj, tk, tgt);
      if (m_pb < PERF_MAX) m_pb++;
      if (mp && m_pm < PERF_MAX) m_pm++;
    end
  endtask

  task automatic lookup(input logic [XLEN-1:0] ipc);
    do_cycle(0, ipc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic update(input logic [XLEN-1:0] ipc, input bit isj,
                        input logic [XLEN-1:0] epc, input bit tk,
                        input logic [XLEN-1:0] tgt, input bit ptk,
                        input logic [XLEN-1:0] pnpc);
    do_cycle(0, ipc, 1, isj, epc, tk, tgt, ptk, pnpc);
  endtask

  // monitor: outputs are combinational, so every driven cycle presents a response
  initial begin
    logic [EXP_W-1:0] e;
    logic             eh, et, em;
    logic [XLEN-1:0]  en, er;
    logic [PERF_W-1:0] eb, epm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        {eh, et, en, em, er, eb, epm} = e;
        check("if_hit", XLEN'(if_hit), XLEN'(eh));
        check("if_pred_taken", XLEN'(if_pred_taken), XLEN'(et));
        check("if_pred_npc", if_pred_npc, en);
        check("ex_mispredict", XLEN'(ex_mispredict), XLEN'(em));
        if (em) check("ex_redirect_pc", ex_redirect_pc, er);
        check("perf_branches", XLEN'(perf_branches), XLEN'(eb));
        check("perf_mispredicts", XLEN'(perf_mispredicts), XLEN'(epm));
      end
    end
  end

  function automatic logic [XLEN-1:0] rand_pc();
    logic [XLEN-1:0] pc;
    if ($urandom_range(0, 9) == 0) pc = $urandom();
    else pc = (XLEN'($urandom_range(0, 3)) << 6) | (XLEN'($urandom_range(0, 15)) << 2)
              | XLEN'($urandom_range(0, 3));
    return pc;
  endfunction

  initial begin
    bit h, t;
    logic [XLEN-1:0] n, epc, tgt, pnpc;
    bit ev, isj, tk, ptk;

    rst = 1; if_pc = '0; ex_valid = 0; ex_is_jump = 0; ex_pc = '0; ex_taken = 0;
    ex_target = '0; ex_pred_taken = 0; ex_pred_npc = '0;
    repeat (2) @(posedge clk);
    model_reset();

    lookup(32'h40);                                          // cold lookup
    update(32'h40, 0, 32'h40, 1, 32'h10, 0, 32'h44);          // allocate, old prediction visible
    update(32'h40, 0, 32'h40, 0, 32'h0, 1, 32'h10);           // hysteresis step 1
    update(32'h40, 0, 32'h40, 0, 32'h0, 0, 32'h44);           // hysteresis step 2
    for (int i = 0; i < 4; i++) update(32'h40, 0, 32'h40, 1, 32'h10, 1, 32'h10);
    update(32'h40, 0, 32'h40, 0, 32'h0, 1, 32'h10);           // saturated, still taken
    lookup(32'h40);
    update(32'h40, 0, 32'h80, 1, 32'h200, 0, 32'h84);         // alias evicts 0x40
    lookup(32'h40);
    lookup(32'h80);
    update(32'h100, 1, 32'h100, 1, 32'h300, 0, 32'h104);      // jump
    update(32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h300);
    lookup(32'h100);
    lookup(32'hFFFF_FFFC);                                    // pc+4 wraps
    update(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h8);
    for (int i = 0; i < 70; i++) update(32'h40, 0, 32'h40, 1, 32'h10, 1, 32'h10);
    lookup(32'h40);                                           // perf_branches saturated
    do_cycle(1, 32'h80, 1, 0, 32'h80, 1, 32'h500, 0, 32'h84); // reset drops update
    lookup(32'h80);
    lookup(32'h100);

    for (int i = 0; i < 400; i++) begin
      ev  = ($urandom_range(0, 9) < 6);
      epc = rand_pc();
      isj = ($urandom_range(0, 4) == 0);
      tk  = isj ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = rand_pc() & ~XLEN'(3);
      if ($urandom_range(0, 3) == 0) begin
        ptk  = 1'($urandom_range(0, 1));
        pnpc = ptk ? tgt : epc + 4;
      end else begin
        model_lookup(epc, h, t, n);
        ptk  = t;
        pnpc = n;
      end
      do_cycle($urandom_range(0, 127) == 0, rand_pc(), ev, isj, epc, tk, tgt, ptk, pnpc);
    end

    @(posedge clk);
    #1;
    ex_valid = 0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
